// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, requester select codes and default timing limits.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        FAULT_D = 2'd3
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_TIMEOUT    = 15;
    localparam int DEF_MAX_STREAK = 4;

endpackage

// File: rtl/mem_arbiter_wdt_counter.sv
// Saturating up-counter with synchronous clear and enable; hit is high while
// the count sits at LIMIT. Clear has priority over enable.
module wdt_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int WIDTH = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    // Count enabled cycles, holding at LIMIT until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + ONE;
        end
    end

    assign hit = (count == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory.
// Handshake: a requester raises x_req with a stable payload; the request is
// accepted in the cycle where x_req && x_gnt, after which the requester waits
// for exactly one x_rvalid or x_err pulse before issuing another request.
// The memory side holds mem_req and payload until the first cycle with
// mem_ack, whose mem_rdata is captured in that same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state
);

    state_t st;
    logic   sel;
    logic   streak_hit;
    logic   to_hit;
    logic   i_acc;
    logic   d_acc;
    logic   d_bad;
    logic   busy;
    logic   can_grant;

    // Data wins ties unless the fetch port has already waited out a full streak.
    always_comb begin
        sel = PORT_D;
        if (!d_req) begin
            sel = PORT_I;
        end else if (i_req && streak_hit) begin
            sel = PORT_I;
        end
    end

    assign can_grant = rst_n && (st == IDLE);
    assign d_gnt     = can_grant && d_req && (sel == PORT_D);
    assign i_gnt     = can_grant && i_req && (sel == PORT_I);
    assign d_acc     = d_req && d_gnt;
    assign i_acc     = i_req && i_gnt;
    assign d_bad     = (d_addr[31:16] != 16'h0000);
    assign busy      = (st == BUSY_I) || (st == BUSY_D);
    assign state     = st;

    // Number of data grants given while a fetch was waiting.
    wdt_counter #(.LIMIT(MAX_STREAK)) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (i_acc || (d_acc && !i_req)),
        .en    (d_acc && i_req),
        .hit   (streak_hit)
    );

    // Busy cycles without an ack; hit marks the last cycle before a fault.
    wdt_counter #(.LIMIT(TIMEOUT - 1)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (i_acc || d_acc),
        .en    (busy && !mem_ack),
        .hit   (to_hit)
    );

    // Arbiter FSM: registers the memory command and the response pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 32'h0;
            i_rvalid  <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= 32'h0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'h0;
        end else begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            case (st)
                IDLE: begin
                    if (d_acc) begin
                        if (d_bad) begin
                            st      <= FAULT_D;
                            d_err   <= 1'b1;
                            d_rdata <= 32'h0;
                        end else begin
                            st        <= BUSY_D;
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_addr  <= d_addr[15:0];
                            mem_wdata <= d_wdata;
                        end
                    end else if (i_acc) begin
                        st        <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_addr  <= i_addr;
                        mem_wdata <= 32'h0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        st      <= IDLE;
                        if (st == BUSY_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? 32'h0 : mem_rdata;
                        end
                    end else if (to_hit) begin
                        mem_req <= 1'b0;
                        st      <= IDLE;
                        if (st == BUSY_I) begin
                            i_err   <= 1'b1;
                            i_rdata <= 32'h0;
                        end else begin
                            d_err   <= 1'b1;
                            d_rdata <= 32'h0;
                        end
                    end
                end
                FAULT_D: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester drivers push expected
// responses at grant time, a memory model replays planned ack delays, and a
// monitor compares every response pulse and the arbitration choice.
module tb_mem_arbiter;

    localparam int TIMEOUT    = 15;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  state;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] i_exp_q[$];
    logic [32:0] d_exp_q[$];
    int          delay_q[$];
    logic [52:0] cmd_q[$];

    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] bus_mem [logic [15:0]];

    int          streak_m;
    logic [31:0] last_i, last_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {a, ~a};
    endfunction

    function automatic logic [31:0] bus_read(input logic [15:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : {a, ~a};
    endfunction

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 4;
        if (r < 17) return TIMEOUT - 1;
        if (r == 17) return TIMEOUT;
        return 30;
    endfunction

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic do_fetch(input logic [15:0] a, input int dly);
        int n, gc;
        i_req = 1'b1; i_addr = a; n = 0;
        #1;
        while (!i_gnt && n < 300) begin @(negedge clk); #1; n++; end
        if (!i_gnt) begin
            fail_now("i_gnt_wait");
            @(negedge clk); i_req = 1'b0;
            return;
        end
        gc = cyc;
        delay_q.push_back(dly);
        cmd_q.push_back({a, 1'b0, 4'hF, 32'h0});
        i_exp_q.push_back(dly < TIMEOUT ? {1'b0, ref_read(a)} : 33'h1_0000_0000);
        @(negedge clk);
        i_req = 1'b0; i_addr = 16'($urandom);
        n = 0;
        while (!(i_rvalid || i_err) && n < 100) begin @(negedge clk); n++; end
        check("i_latency", 64'(cyc - gc), 64'(dly < TIMEOUT ? dly + 2 : TIMEOUT + 1));
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, input int dly);
        int n, gc, lat;
        logic [32:0] e;
        d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; n = 0;
        #1;
        while (!d_gnt && n < 300) begin @(negedge clk); #1; n++; end
        if (!d_gnt) begin
            fail_now("d_gnt_wait");
            @(negedge clk); d_req = 1'b0;
            return;
        end
        gc = cyc;
        if (a[31:16] != 16'h0) begin
            e = 33'h1_0000_0000; lat = 1;
        end else begin
            delay_q.push_back(dly);
            cmd_q.push_back({a[15:0], we, be, wd});
            lat = (dly < TIMEOUT) ? dly + 2 : TIMEOUT + 1;
            if (dly >= TIMEOUT) e = 33'h1_0000_0000;
            else if (we) begin
                e = 33'h0;
                ref_mem[a[15:0]] = merge(ref_read(a[15:0]), wd, be);
            end else e = {1'b0, ref_read(a[15:0])};
        end
        d_exp_q.push_back(e);
        @(negedge clk);
        d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom;
        n = 0;
        while (!(d_rvalid || d_err) && n < 100) begin @(negedge clk); n++; end
        check("d_latency", 64'(cyc - gc), 64'(lat));
    endtask

    // ---------------- memory model ----------------
    bit          active;
    int          hi_cnt, dly_m;
    logic [52:0] cap;

    initial begin
        mem_ack = 1'b0; mem_rdata = 32'h0; active = 1'b0; hi_cnt = 0; dly_m = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0; mem_ack = 1'b0;
            end else begin
                if (active && !mem_req) begin
                    check("mem_req_cycles", 64'(hi_cnt), 64'(dly_m < TIMEOUT ? dly_m + 1 : TIMEOUT));
                    active = 1'b0;
                end
                if (mem_req && !active) begin
                    active = 1'b1; hi_cnt = 0;
                    cap = {mem_addr, mem_we, mem_be, mem_wdata};
                    if (delay_q.size() == 0 || cmd_q.size() == 0) begin
                        fail_now("mem_unexpected_cmd"); dly_m = 0;
                    end else begin
                        dly_m = delay_q.pop_front();
                        check("mem_cmd", cap, cmd_q.pop_front());
                    end
                end else if (active) begin
                    check("mem_stable", {mem_addr, mem_we, mem_be, mem_wdata}, cap);
                end
                if (active) begin
                    if (hi_cnt == dly_m) begin
                        mem_ack = 1'b1;
                        if (cap[36]) begin
                            mem_rdata = $urandom;
                            bus_mem[cap[52:37]] = merge(bus_read(cap[52:37]), cap[31:0], cap[35:32]);
                        end else mem_rdata = bus_read(cap[52:37]);
                    end else begin
                        mem_ack = 1'b0; mem_rdata = $urandom;
                    end
                    hi_cnt++;
                end else begin
                    // Stray acks while no command is pending must be ignored.
                    mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [32:0] e;
        streak_m = 0; last_i = 0; last_d = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                streak_m = 0; last_i = 0; last_d = 0;
            end else begin
                if (i_gnt || d_gnt) begin
                    check("gnt_excl", {62'h0, i_gnt && d_gnt, mem_req}, 64'h0);
                    if (i_req && d_req) check("arb_sel", 64'(d_gnt), 64'(streak_m != MAX_STREAK));
                    if (d_gnt) streak_m = i_req ? ((streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK) : 0;
                    else streak_m = 0;
                end
                if (i_rvalid || i_err || d_rvalid || d_err)
                    check("one_pulse", 64'($countones({i_rvalid, i_err, d_rvalid, d_err})), 64'h1);
                if (i_rvalid || i_err) begin
                    if (i_exp_q.size() == 0) fail_now("i_unexpected_resp");
                    else begin
                        e = i_exp_q.pop_front();
                        check("i_resp", {i_err, i_rvalid, i_rdata}, {e[32], ~e[32], e[31:0]});
                        last_i = e[31:0];
                    end
                end else check("i_hold", i_rdata, last_i);
                if (d_rvalid || d_err) begin
                    if (d_exp_q.size() == 0) fail_now("d_unexpected_resp");
                    else begin
                        e = d_exp_q.pop_front();
                        check("d_resp", {d_err, d_rvalid, d_rdata}, {e[32], ~e[32], e[31:0]});
                        last_d = e[31:0];
                    end
                end else check("d_hold", d_rdata, last_d);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] a;
        int pulses;
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 16'h0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
        d_addr = 32'h0; d_wdata = 32'h0;
        ref_mem[16'h0040] = 32'h00A00093;
        bus_mem[16'h0040] = 32'h00A00093;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 64'h0);
        check("rst_gnt", {i_gnt, d_gnt}, 64'h0);
        check("rst_resp", {i_rvalid, i_err, d_rvalid, d_err}, 64'h0);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rst_state", state, 64'h0);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_fetch(16'h0040, 0);
        do_data(1'b1, 4'b0011, 32'h0000_1234, 32'hDEAD_BEEF, 3);
        do_data(1'b0, 4'hF, 32'h0000_1234, 32'h0, 0);
        do_fetch(16'h0080, 30);
        do_fetch(16'h0084, TIMEOUT - 1);
        do_fetch(16'h0088, TIMEOUT);
        do_data(1'b0, 4'hF, 32'h0001_0000, 32'h0, 0);
        do_data(1'b1, 4'hF, 32'h0000_0010, 32'h0BAD_F00D, 30);
        do_data(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1);

        // Both ports saturated with immediate acks
        fork
            begin for (int k = 0; k < 3; k++) do_fetch(16'(16'h0200 + k * 4), 0); end
            begin for (int k = 0; k < 14; k++) do_data(1'b0, 4'hF, 32'(32'h0300 + k * 4), 32'h0, 0); end
        join

        // Randomised traffic
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_fetch(16'($urandom_range(0, 63)), pick_delay());
                end
            end
            begin
                logic [31:0] ra;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if ($urandom_range(0, 7) == 0) ra = {16'($urandom_range(1, 65535)), 16'($urandom)};
                    else ra = 32'($urandom_range(0, 63));
                    do_data(1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom, pick_delay());
                end
            end
        join

        // Reset while a fetch is in flight
        i_req = 1'b1; i_addr = 16'h0100; n = 0;
        #1;
        while (!i_gnt && n < 50) begin @(negedge clk); #1; n++; end
        check("abort_gnt", i_gnt, 64'h1);
        delay_q.push_back(40);
        cmd_q.push_back({16'h0100, 1'b0, 4'hF, 32'h0});
        @(negedge clk); i_req = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy", state, 64'h1);
        rst_n = 1'b0; i_req = 1'b1;
        @(negedge clk); #1;
        check("abort_mem_req", mem_req, 64'h0);
        check("abort_gnt_low", i_gnt, 64'h0);
        check("abort_state", state, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; i_req = 1'b0;
        delay_q.delete(); cmd_q.delete();
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (i_rvalid || i_err || mem_req) pulses++;
        end
        check("abort_silent", 64'(pulses), 64'h0);

        // Saturated traffic again: arbitration must restart from an empty streak
        fork
            begin for (int k = 0; k < 2; k++) do_fetch(16'(16'h0020 + k), 0); end
            begin for (int k = 0; k < 9; k++) do_data(1'b0, 4'hF, 32'(32'h0030 + k), 32'h0, 0); end
        join

        repeat (5) @(negedge clk);
        check("queues_empty", 64'(i_exp_q.size() + d_exp_q.size() + delay_q.size() + cmd_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
